controller_input_conditioner: RTL and testbench
===============================================

Name: controller_input_conditioner

Overview:
- Sits directly upstream of the memory-mapped I/O block and conditions the raw 36-pin controller GPIO bus before the processor polls it.
- Per pin: 2-flop synchronizer, polarity normalization, counter-based debounce, rising-edge "press" capture.
- Presents two 18-bit player words (stable state plus sticky press flags) that the I/O block maps to load addresses.
- The I/O block clears the press flags with a per-player pulse when the processor reads them.

Parameters:
- NUM_PINS, 36: total GPIO pins; must equal 2*P_WIDTH.
- P_WIDTH, 18: bits per player; pins [17:0] = player 1, pins [35:18] = player 2.
- DEBOUNCE_CYCLES, 500000: consecutive disagreeing cycles needed to accept a new level (10 ms at 50 MHz); must be >= 2.
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 = pin low means pressed, so the synced pin is inverted before debounce.

Ports:
- clock, input, 1: system clock (same clock as processor and I/O block).
- reset_btn, input, 1: asynchronous active-low reset.
- gpio, input, NUM_PINS: raw controller pins, asynchronous to clock.
- clr_p1, input, 1: one-cycle pulse; clears p1_press.
- clr_p2, input, 1: one-cycle pulse; clears p2_press.
- p1_state, output, P_WIDTH: debounced pressed-state, player 1.
- p2_state, output, P_WIDTH: debounced pressed-state, player 2.
- p1_press, output, P_WIDTH: sticky rising-edge flags, player 1.
- p2_press, output, P_WIDTH: sticky rising-edge flags, player 2.
- change, output, 1: one-cycle pulse when any debounced bit changes.

Behaviour:
- Reset (reset_btn low, asynchronous):
  - All sync flops, counters, stable bits, press flags and change go to 0.
  - Stable 0 means not pressed regardless of ACTIVE_LOW.
  - Outputs stay 0 while reset is held; release is sampled on the next rising clock edge.
- Synchronizer:
  - s1 <= gpio, s2 <= s1.
  - norm = s2 ^ ACTIVE_LOW.
  - Reset value 0 in s1/s2 means norm = 1 when ACTIVE_LOW = 1, so this rule is required: stable does not change for DEBOUNCE_CYCLES after reset even if a pin reads pressed. No glitch press occurs because the counter must fill.
- Debounce, per pin:
  - If norm == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then stable <= norm and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any single-cycle agreement restarts the count.
  - Latency from a clean pin edge to the stable change: 2 + DEBOUNCE_CYCLES clock edges.
- Press flags, per bit:
  - Set when stable goes 0->1 in this cycle.
  - Cleared by the matching clr_pN.
  - Set and clear in the same cycle: set wins, so no press is lost.
  - A release (1->0) never touches the flag.
- change: registered; high for exactly one cycle after the edge on which any stable bit changed. Multiple bits changing together give one pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The counter never wraps: it saturates at DEBOUNCE_CYCLES-1 by construction.

Optional Feature:
- Macro: CTRL_PRESS_LATCH_EN.
- Defined: press flags behave as above.
- Undefined:
  - Press logic is omitted.
  - p1_press/p2_press are driven constant 0.
  - clr_p1/clr_p2 are ignored; they are kept as ports so the I/O block wiring is unchanged.
  - The processor then polls p*_state only.

Decomposition:
- Shared package holds:
  - P_WIDTH.
  - Button bit-index constants: BTN_A, BTN_B, BTN_JUMP, BTN_SHIELD, BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_START, with remaining bits reserved.
  - The default DEBOUNCE_CYCLES constant, shared with the I/O block address map.
- One sub-module: debounce_bit, containing sync flops, polarity, counter and the stable bit for a single pin. It is instantiated NUM_PINS times by a generate loop.
- The top level holds the press flags, the change pulse and the player split.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset with all gpio=1, hold 10 cycles, release:
  - All outputs 0 throughout.
  - After release and 20 idle cycles, all outputs still 0.
- Drive gpio[0]=0 (clean) at cycle T:
  - p1_state[0]=1 and p1_press[0]=1 visible after edge T+6.
  - change high for exactly one cycle.
  - p2_* unchanged.
- Bounce gpio[20] low for 3 cycles, high 1, low 3, then high:
  - p2_state[2] and p2_press[2] never set.
  - change never pulses.
- With p1_press[0]=1, pulse clr_p1 on the same edge that gpio[0]'s new press is accepted (press, release, re-press):
  - p1_press[0] stays 1.
  - A clr_p1 pulse one cycle later clears it to 0.
- Press gpio[5] and gpio[30] on the same cycle:
  - p1_state[5] and p2_state[12] rise on the same edge.
  - A single change pulse.
- Assert reset_btn low mid-count (cnt=2), with no clock edge required:
  - All outputs drop to 0 asynchronously.
  - After release, the pin needs the full 2+4 cycles again.

Source files
------------

// File: rtl/controller_input_conditioner_pkg.sv
// Shared constants for the controller input conditioner and the I/O block address map.
package controller_input_conditioner_pkg;

  localparam int P_WIDTH                 = 18;
  localparam int NUM_PINS                = 2 * P_WIDTH;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT           = 19;

  // Bit positions inside a player word; bits 9..17 are reserved.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SHIELD = 3;
  localparam int BTN_LEFT   = 4;
  localparam int BTN_RIGHT  = 5;
  localparam int BTN_UP     = 6;
  localparam int BTN_DOWN   = 7;
  localparam int BTN_START  = 8;

endpackage

// File: rtl/controller_input_conditioner_debounce_bit.sv
// One GPIO pin: 2-flop synchronizer, polarity normalization and counter debounce.
module controller_input_conditioner_debounce_bit
  import controller_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic reset_btn,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic toggle
);

  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             norm;
  logic             accept;

  // Counter only advances while norm disagrees with stable, so it tops out at CNT_LAST.
  always_comb begin
    norm     = s2_q ^ POL;
    accept   = (norm != stable_q) && (cnt_q == CNT_LAST);
    s1_d     = pin;
    s2_d     = s1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (norm == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = norm;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  assign toggle = accept;
  assign rise   = accept & norm;

endmodule

// File: rtl/controller_input_conditioner.sv
// Conditions the 36-pin controller bus into two player words.
// Optional press latching is built only when CTRL_PRESS_LATCH_EN is defined.
module controller_input_conditioner #(
  parameter int NUM_PINS        = controller_input_conditioner_pkg::NUM_PINS,
  parameter int P_WIDTH         = controller_input_conditioner_pkg::P_WIDTH,
  parameter int DEBOUNCE_CYCLES = controller_input_conditioner_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = controller_input_conditioner_pkg::CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clock,
  input  logic                reset_btn,
  input  logic [NUM_PINS-1:0] gpio,
  input  logic                clr_p1,
  input  logic                clr_p2,
  output logic [P_WIDTH-1:0]  p1_state,
  output logic [P_WIDTH-1:0]  p2_state,
  output logic [P_WIDTH-1:0]  p1_press,
  output logic [P_WIDTH-1:0]  p2_press,
  output logic                change
);

  import controller_input_conditioner_pkg::*;

  logic [NUM_PINS-1:0] stable;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] toggle;
  logic                change_q, change_d;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    controller_input_conditioner_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_db (
      .clock     (clock),
      .reset_btn (reset_btn),
      .pin       (gpio[g]),
      .stable    (stable[g]),
      .rise      (rise[g]),
      .toggle    (toggle[g])
    );
  end

  // One pulse however many pins flip on the same edge.
  always_comb begin
    change_d = |toggle;
  end

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) change_q <= 1'b0;
    else            change_q <= change_d;
  end

`ifdef CTRL_PRESS_LATCH_EN
  logic [NUM_PINS-1:0] press_q, press_d;
  logic [NUM_PINS-1:0] clr_vec;

  // Setting after clearing means a press arriving with a clear is kept.
  always_comb begin
    clr_vec = {{P_WIDTH{clr_p2}}, {P_WIDTH{clr_p1}}};
    press_d = (press_q & ~clr_vec) | rise;
  end

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) press_q <= '0;
    else            press_q <= press_d;
  end

  assign p1_press = press_q[P_WIDTH-1:0];
  assign p2_press = press_q[NUM_PINS-1:P_WIDTH];
`else
  logic unused_press_inputs;
  assign unused_press_inputs = clr_p1 ^ clr_p2 ^ (^rise);
  assign p1_press = '0;
  assign p2_press = '0;
`endif

  assign p1_state = stable[P_WIDTH-1:0];
  assign p2_state = stable[NUM_PINS-1:P_WIDTH];
  assign change   = change_q;

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Directed bench for controller_input_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_controller_input_conditioner;

  localparam int NP = 36;
  localparam int PW = 18;

  logic          clock = 1'b0;
  logic          reset_btn;
  logic [NP-1:0] gpio;
  logic          clr_p1, clr_p2;
  logic [PW-1:0] p1_state, p2_state, p1_press, p2_press;
  logic          change;

  int total = 0;
  int bad   = 0;

  controller_input_conditioner #(
    .NUM_PINS        (NP),
    .P_WIDTH         (PW),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .ACTIVE_LOW      (1)
  ) dut (
    .clock     (clock),
    .reset_btn (reset_btn),
    .gpio      (gpio),
    .clr_p1    (clr_p1),
    .clr_p2    (clr_p2),
    .p1_state  (p1_state),
    .p2_state  (p2_state),
    .p1_press  (p1_press),
    .p2_press  (p2_press),
    .change    (change)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NP-1:0] gpio;
    logic          c1;
    logic          c2;
    int            n;
    logic [PW-1:0] e1s;
    logic [PW-1:0] e2s;
    logic [PW-1:0] e1p;
    logic [PW-1:0] e2p;
    logic          ech;
  } vec_t;

  localparam logic [NP-1:0] ALL = '1;

  function automatic logic [PW-1:0] pexp(input logic [PW-1:0] v);
`ifdef CTRL_PRESS_LATCH_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [PW-1:0] e1s, input logic [PW-1:0] e2s,
                         input logic [PW-1:0] e1p, input logic [PW-1:0] e2p, input logic ech);
    chk({tag, " p1_state"}, NP'(p1_state), NP'(e1s));
    chk({tag, " p2_state"}, NP'(p2_state), NP'(e2s));
    chk({tag, " p1_press"}, NP'(p1_press), NP'(pexp(e1p)));
    chk({tag, " p2_press"}, NP'(p2_press), NP'(pexp(e2p)));
    chk({tag, " change"},   NP'(change),   NP'(ech));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [19];
    logic [NP-1:0] g0, g0_20, g0_5_30;
    g0      = ALL & ~(NP'(1) << 0);
    g0_20   = g0 & ~(NP'(1) << 20);
    g0_5_30 = g0 & ~(NP'(1) << 5) & ~(NP'(1) << 30);

    // Idle, clean press of pin 0, bounce on pin 20, release, clear-vs-set, dual press, clr_p2.
    vt[0]  = '{ALL,     1'b0, 1'b0, 20, 18'h0,  18'h0,    18'h0,  18'h0,    1'b0};
    vt[1]  = '{g0,      1'b0, 1'b0, 5,  18'h0,  18'h0,    18'h0,  18'h0,    1'b0};
    vt[2]  = '{g0,      1'b0, 1'b0, 1,  18'h1,  18'h0,    18'h1,  18'h0,    1'b1};
    vt[3]  = '{g0,      1'b0, 1'b0, 1,  18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[4]  = '{g0_20,   1'b0, 1'b0, 3,  18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[5]  = '{g0,      1'b0, 1'b0, 1,  18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[6]  = '{g0_20,   1'b0, 1'b0, 3,  18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[7]  = '{g0,      1'b0, 1'b0, 10, 18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[8]  = '{ALL,     1'b0, 1'b0, 5,  18'h1,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[9]  = '{ALL,     1'b0, 1'b0, 1,  18'h0,  18'h0,    18'h1,  18'h0,    1'b1};
    vt[10] = '{ALL,     1'b0, 1'b0, 1,  18'h0,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[11] = '{g0,      1'b0, 1'b0, 5,  18'h0,  18'h0,    18'h1,  18'h0,    1'b0};
    vt[12] = '{g0,      1'b1, 1'b0, 1,  18'h1,  18'h0,    18'h1,  18'h0,    1'b1};
    vt[13] = '{g0,      1'b1, 1'b0, 1,  18'h1,  18'h0,    18'h0,  18'h0,    1'b0};
    vt[14] = '{g0,      1'b0, 1'b0, 2,  18'h1,  18'h0,    18'h0,  18'h0,    1'b0};
    vt[15] = '{g0_5_30, 1'b0, 1'b0, 5,  18'h1,  18'h0,    18'h0,  18'h0,    1'b0};
    vt[16] = '{g0_5_30, 1'b0, 1'b0, 1,  18'h21, 18'h1000, 18'h20, 18'h1000, 1'b1};
    vt[17] = '{g0_5_30, 1'b0, 1'b0, 1,  18'h21, 18'h1000, 18'h20, 18'h1000, 1'b0};
    vt[18] = '{g0_5_30, 1'b0, 1'b1, 1,  18'h21, 18'h1000, 18'h20, 18'h0,    1'b0};

    reset_btn = 1'b0;
    gpio      = ALL;
    clr_p1    = 1'b0;
    clr_p2    = 1'b0;
    #1;
    chk_all("reset t0", 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk_all($sformatf("reset hold c%0d", c), 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    end
    reset_btn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      gpio   = vt[i].gpio;
      clr_p1 = vt[i].c1;
      clr_p2 = vt[i].c2;
      for (int c = 0; c < vt[i].n; c++) begin
        step();
        chk_all($sformatf("v%0d c%0d", i, c), vt[i].e1s, vt[i].e2s, vt[i].e1p, vt[i].e2p, vt[i].ech);
      end
    end
    clr_p1 = 1'b0;
    clr_p2 = 1'b0;

    // Start pin 1 counting, then pull reset between clock edges with the count at 2.
    gpio = g0_5_30 & ~(NP'(1) << 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk_all($sformatf("pre-reset c%0d", c), 18'h21, 18'h1000, 18'h20, 18'h0, 1'b0);
    end
    #2;
    reset_btn = 1'b0;
    gpio      = ALL;
    #1;
    chk_all("async reset", 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk_all($sformatf("reset held c%0d", c), 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    end
    reset_btn = 1'b1;

    // Synchronizer reset value reads as pressed for two edges; counter must not fill.
    for (int c = 0; c < 3; c++) begin
      step();
      chk_all($sformatf("post-reset idle c%0d", c), 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    end
    gpio = ALL & ~(NP'(1) << 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all($sformatf("post-reset press c%0d", c), 18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    end
    step();
    chk_all("post-reset accept", 18'h2, 18'h0, 18'h2, 18'h0, 1'b1);
    step();
    chk_all("post-reset settle", 18'h2, 18'h0, 18'h2, 18'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
